// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - arbitrated SPI mode-0 master, one addr+data frame per grant; option macro SPI_ARB_FIXED_PRIO_EN
module spi_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [NUM_REQ-1:0]       reqValid,
    input  logic [NUM_REQ*8-1:0]     reqAddr,
    input  logic [NUM_REQ*LEN_W-1:0] reqLen,
    input  logic [NUM_REQ*8-1:0]     txData,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     txTake,
    output logic [7:0]               rxData,
    output logic                     rxValid,
    output logic                     busy,
    output logic                     cs,
    output logic                     sck,
    output logic                     mosi,
    input  logic                     miso
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [LEN_W-1:0]   byte_idx;   // 0 = address byte, 1..len_q = data bytes
    logic [LEN_W-1:0]   len_q;
    logic [6:0]         tx_sh;      // bits still to send after the one on mosi
    logic [7:0]         rx_sh;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   arb_base;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign arb_base = '0;
`else
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    logic [PTR_W-1:0]   ptr;
    assign arb_base = ptr;
`endif

    // Pick the first asserted request at or after arb_base, wrapping; the
    // descending loop lets the smallest offset overwrite the others.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (reqValid[(int'(arb_base) + i) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'((int'(arb_base) + i) % NUM_REQ);
            end
        end
    end

    // Frame sequencer: arbitration, chip select framing, bit shifting, gap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            len_q    <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            gnt_idx  <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
            grant    <= '0;
            txTake   <= 1'b0;
            rxData   <= 8'h00;
            rxValid  <= 1'b0;
            busy     <= 1'b0;
            cs       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            txTake  <= 1'b0;
            rxValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= NUM_REQ'(1) << pick_idx;
                        gnt_idx  <= pick_idx;
                        busy     <= 1'b1;
                        cs       <= 1'b0;
                        len_q    <= reqLen[LEN_W*pick_idx +: LEN_W];
                        mosi     <= reqAddr[8*pick_idx + 7];
                        tx_sh    <= reqAddr[8*pick_idx +: 7];
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                        state    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_END) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!sck) begin
                            sck   <= 1'b1;
                            rx_sh <= {rx_sh[6:0], miso};
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                mosi    <= tx_sh[6];
                                tx_sh   <= {tx_sh[5:0], 1'b0};
                            end else begin
                                bit_cnt <= '0;
                                // The address byte's miso content is never reported.
                                if (byte_idx != '0) begin
                                    rxData  <= rx_sh;
                                    rxValid <= 1'b1;
                                end
                                if (byte_idx == len_q) begin
                                    mosi  <= 1'b0;
                                    state <= CS_HOLD;
                                end else begin
                                    byte_idx <= byte_idx + 1'b1;
                                    mosi     <= txData[8*gnt_idx + 7];
                                    tx_sh    <= txData[8*gnt_idx +: 7];
                                    txTake   <= 1'b1;
                                end
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        grant <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
                        ptr   <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
`endif
                        state <= CS_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
